// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: request/result bundle between an add requester and
// serial_adder_ctrl.
//   start       request pulse (requester -> controller)
//   a, b, c_in  operands and carry-in, sampled on an accepted start
//   busy        serial add in progress
//   done        one-cycle completion pulse
//   sum, c_out  registered result
//   ovf         signed overflow, only when SERIAL_ADDER_OVF_EN is defined
// Modports: master = requester, slave = controller.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out, ovf
  );
  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out, ovf
  );
`else
  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );
  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );
`endif
endinterface

// File: rtl/fullAdder.sv
// fullAdder: gate-level one-bit full adder cell.
//   a, b, c_in  addend bits and carry-in
//   sum         a ^ b ^ c_in
//   carry       majority(a, b, c_in)
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic carry
);
  logic axb;
  logic gen;
  logic prop;

  xor u_x0 (axb, a, b);
  xor u_x1 (sum, axb, c_in);
  and u_a0 (gen, a, b);
  and u_a1 (prop, axb, c_in);
  or  u_o0 (carry, gen, prop);
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller. Adds two WIDTH-bit operands
// LSB first through a single fullAdder cell, one bit per clock.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   serial_adder_ctrl_if.slave: start/a/b/c_in in, busy/done/sum/c_out
//         (and ovf) out
// Optional feature: define SERIAL_ADDER_OVF_EN to add the registered signed
// overflow output ovf.
// Timing: start accepted at edge E0 -> busy high through E_WIDTH, done pulses
// at E_WIDTH with sum/c_out valid; start held during the done cycle is
// accepted at E_WIDTH+1. start while busy is ignored.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_sum;
  logic fa_carry;
  logic accept;
  logic last_bit;

  fullAdder u_fa (
    .a     (opa_q[0]),
    .b     (opb_q[0]),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign accept   = bus.start && (state_q != StRun);
  assign last_bit = (state_q == StRun) && (cnt_q == CntLast);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (last_bit)  state_d = StDone;
      StDone:  state_d = bus.start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs are pure state decodes, so busy and done are exclusive.
  always_comb begin
    bus.busy = (state_q == StRun);
    bus.done = (state_q == StDone);
  end

  // Datapath next state
  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      opa_d   = bus.a;
      opb_d   = bus.b;
      carry_d = bus.c_in;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (state_q == StRun) begin
      acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
      opa_d   = {1'b0, opa_q[WIDTH-1:1]};
      opb_d   = {1'b0, opb_q[WIDTH-1:1]};
      carry_d = fa_carry;
      cnt_d   = cnt_q + 1'b1;
      if (last_bit) begin
        sum_d   = {fa_sum, acc_q[WIDTH-1:1]};
        c_out_d = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
        // On the last bit carry_q is the carry into the MSB.
        ovf_d   = carry_q ^ fa_carry;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed self-checking bench for serial_adder_ctrl
// with WIDTH=8.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  serial_adder_ctrl_if #(.WIDTH(8)) bus ();

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Waits for done, counting edges (lat, starting from lat0) and busy samples.
  task automatic wait_done(input int lat0, output int lat, output int bcnt, output bit to);
    lat  = lat0;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < lat0 + 40) begin
      if (bus.busy === 1'b1) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    to = (bus.done !== 1'b1);
  endtask

  // Issues one start; returns after the E0 edge (+1) with start dropped.
  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.c_in  = cv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++;
      $display("FAIL reset_done: got %b expected 0", bus.done); end
    tests_run++; if (bus.sum !== 8'h00) begin tests_failed++;
      $display("FAIL reset_sum: got %h expected 00", bus.sum); end
    tests_run++; if (bus.c_out !== 1'b0) begin tests_failed++;
      $display("FAIL reset_c_out: got %b expected 0", bus.c_out); end
`ifdef SERIAL_ADDER_OVF_EN
    tests_run++; if (bus.ovf !== 1'b0) begin tests_failed++;
      $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero();
    int lat, bcnt;
    bit to;
    issue(8'h00, 8'h00, 1'b0);
    wait_done(0, lat, bcnt, to);
    tests_run++; if (to) begin tests_failed++;
      $display("FAIL zero_timeout: got no done expected done"); end
    tests_run++; if (lat !== 8) begin tests_failed++;
      $display("FAIL zero_latency: got %0d expected 8", lat); end
    tests_run++; if (bcnt !== 8) begin tests_failed++;
      $display("FAIL zero_busy_cycles: got %0d expected 8", bcnt); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++;
      $display("FAIL zero_busy_at_done: got %b expected 0", bus.busy); end
    tests_run++; if (bus.sum !== 8'h00 || bus.c_out !== 1'b0) begin tests_failed++;
      $display("FAIL zero_result: got %b_%h expected 0_00", bus.c_out, bus.sum); end
    @(posedge clk);
    #1;
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++;
      $display("FAIL zero_done_pulse: got %b expected 0", bus.done); end
  endtask

  task automatic test_vectors();
    logic [7:0] va[3];
    logic [7:0] vb[3];
    logic       vc[3];
    logic [7:0] es[3];
    logic       ec[3];
    logic       eo[3];
    int lat, bcnt;
    bit to;
    va = '{8'h5A, 8'hFF, 8'hFF};
    vb = '{8'h3C, 8'h01, 8'hFF};
    vc = '{1'b0, 1'b0, 1'b1};
    es = '{8'h96, 8'h00, 8'hFF};
    ec = '{1'b0, 1'b1, 1'b1};
    eo = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], vc[i]);
      wait_done(0, lat, bcnt, to);
      tests_run++; if (to || lat !== 8) begin tests_failed++;
        $display("FAIL vec%0d_latency: got %0d expected 8", i, lat); end
      tests_run++; if (bus.sum !== es[i]) begin tests_failed++;
        $display("FAIL vec%0d_sum: got %h expected %h", i, bus.sum, es[i]); end
      tests_run++; if (bus.c_out !== ec[i]) begin tests_failed++;
        $display("FAIL vec%0d_c_out: got %b expected %b", i, bus.c_out, ec[i]); end
`ifdef SERIAL_ADDER_OVF_EN
      tests_run++; if (bus.ovf !== eo[i]) begin tests_failed++;
        $display("FAIL vec%0d_ovf: got %b expected %b", i, bus.ovf, eo[i]); end
`else
      if (eo[i] === 1'bx) $display("note: unreachable");
`endif
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    bit to;
    issue(8'h10, 8'h20, 1'b0);
    @(posedge clk);
    @(posedge clk);
    // Start pulse at E3 while running must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h77;
    bus.b     = 8'h11;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    tests_run++; if (bus.sum !== 8'hFF) begin tests_failed++;
      $display("FAIL b2b_sum_held_run: got %h expected FF", bus.sum); end
    wait_done(3, lat, bcnt, to);
    tests_run++; if (to || lat !== 8) begin tests_failed++;
      $display("FAIL b2b_first_latency: got %0d expected 8", lat); end
    tests_run++; if (bus.sum !== 8'h30 || bus.c_out !== 1'b0) begin tests_failed++;
      $display("FAIL b2b_first_sum: got %b_%h expected 0_30", bus.c_out, bus.sum); end
    // Start held during the done cycle.
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    bus.c_in  = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    tests_run++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin tests_failed++;
      $display("FAIL b2b_restart: got busy=%b done=%b expected busy=1 done=0",
               bus.busy, bus.done); end
    tests_run++; if (bus.sum !== 8'h30) begin tests_failed++;
      $display("FAIL b2b_sum_hold: got %h expected 30", bus.sum); end
    wait_done(9, lat, bcnt, to);
    tests_run++; if (to || lat !== 17) begin tests_failed++;
      $display("FAIL b2b_second_edge: got E%0d expected E17", lat); end
    tests_run++; if (bus.sum !== 8'h02 || bus.c_out !== 1'b0) begin tests_failed++;
      $display("FAIL b2b_second_sum: got %b_%h expected 0_02", bus.c_out, bus.sum); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort();
    int lat, bcnt;
    bit to;
    bit saw_done;
    issue(8'hAA, 8'h55, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    rst = 1'b1;
    #1;
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++;
      $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    tests_run++; if (bus.sum !== 8'h00 || bus.c_out !== 1'b0) begin tests_failed++;
      $display("FAIL abort_sum: got %b_%h expected 0_00", bus.c_out, bus.sum); end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    tests_run++; if (saw_done) begin tests_failed++;
      $display("FAIL abort_no_done: got done pulse expected none"); end
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b1;
    bus.a     = 8'h03;
    bus.b     = 8'h04;
    bus.c_in  = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++;
      $display("FAIL abort_first_edge: got busy=%b expected 1", bus.busy); end
    wait_done(0, lat, bcnt, to);
    tests_run++; if (to || lat !== 8) begin tests_failed++;
      $display("FAIL abort_new_latency: got %0d expected 8", lat); end
    tests_run++; if (bus.sum !== 8'h07 || bus.c_out !== 1'b0) begin tests_failed++;
      $display("FAIL abort_new_sum: got %b_%h expected 0_07", bus.c_out, bus.sum); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c_in  = 1'b0;
    test_reset();
    test_zero();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
